// File: rtl/reg_access_sequencer_if.sv
// Request/response handshake and register-file bus shared by the sequencer,
// the control unit that issues requests and the register file it drives.
interface reg_access_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    // Both handshakes: a transfer happens on a rising edge where valid and
    // ready are both high; the offering side holds its payload stable until then.
    logic              Req_Valid;
    logic              Req_Ready;
    logic [1:0]        Req_Op;
    logic [ADDR_W-1:0] Req_Ra;
    logic [ADDR_W-1:0] Req_Rb;
    logic [DATA_W-1:0] Req_Imm;
    logic              Rsp_Valid;
    logic              Rsp_Ready;
    logic [DATA_W-1:0] Rsp_Data;
    logic [ADDR_W-1:0] RF_Addr;
    logic [DATA_W-1:0] RF_Wdata;
    logic              RF_We;
    logic [DATA_W-1:0] RF_Rdata;

    // Environment side: request producer, response consumer and register file.
    modport master (
        output Req_Valid, Req_Op, Req_Ra, Req_Rb, Req_Imm, Rsp_Ready, RF_Rdata,
        input  Req_Ready, Rsp_Valid, Rsp_Data, RF_Addr, RF_Wdata, RF_We
    );

    // Sequencer side.
    modport slave (
        input  Req_Valid, Req_Op, Req_Ra, Req_Rb, Req_Imm, Rsp_Ready, RF_Rdata,
        output Req_Ready, Rsp_Valid, Rsp_Data, RF_Addr, RF_Wdata, RF_We
    );
endinterface

// File: rtl/reg_access_sequencer.sv
// Multi-cycle initiator for a single-port register file: READ, WRITE,
// ADD-immediate and SWAP, sequenced as separate read and write cycles.
module reg_access_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                  Clk,
    input  logic                  Reset,
    reg_access_sequencer_if.slave bus,
    output logic [2:0]            Dbg_State_o
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RDA  = 3'd1,
        RDB  = 3'd2,
        WRA  = 3'd3,
        WRB  = 3'd4,
        RESP = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_ADD   = 2'd2,
        OP_SWAP  = 2'd3
    } op_t;

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [ADDR_W-1:0] ra_q, ra_d;
    logic [ADDR_W-1:0] rb_q, rb_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] tmp_a_q, tmp_a_d;
    logic [DATA_W-1:0] tmp_b_q, tmp_b_d;
    logic [DATA_W-1:0] sum_d;

    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              rf_we_q, rf_we_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              req_ready_q, req_ready_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        imm_d   = imm_q;
        tmp_a_d = tmp_a_q;
        tmp_b_d = tmp_b_q;

        case (state_q)
            IDLE: begin
                if (bus.Req_Valid && req_ready_q) begin
                    op_d    = op_t'(bus.Req_Op);
                    ra_d    = bus.Req_Ra;
                    rb_d    = bus.Req_Rb;
                    imm_d   = bus.Req_Imm;
                    state_d = (op_t'(bus.Req_Op) == OP_WRITE) ? WRA : RDA;
                end
            end
            RDA: begin
                tmp_a_d = bus.RF_Rdata;
                if (op_q == OP_SWAP)      state_d = RDB;
                else if (op_q == OP_READ) state_d = RESP;
                else                      state_d = WRA;
            end
            RDB: begin
                tmp_b_d = bus.RF_Rdata;
                state_d = WRA;
            end
            WRA:     state_d = (op_q == OP_SWAP) ? WRB : RESP;
            WRB:     state_d = RESP;
            RESP:    if (bus.Rsp_Ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        sum_d = tmp_a_d + imm_d;

        // Outputs are registered, so they are decoded from the state being entered.
        rf_addr_d   = '0;
        rf_wdata_d  = '0;
        rf_we_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        req_ready_d = 1'b0;

        case (state_d)
            IDLE: req_ready_d = 1'b1;
            RDA:  rf_addr_d = ra_d;
            RDB:  rf_addr_d = rb_d;
            WRA: begin
                rf_addr_d = ra_d;
                rf_we_d   = 1'b1;
                case (op_d)
                    OP_WRITE: rf_wdata_d = imm_d;
                    OP_ADD:   rf_wdata_d = sum_d;
                    OP_SWAP:  rf_wdata_d = tmp_b_d;
                    default:  rf_wdata_d = '0;
                endcase
            end
            WRB: begin
                rf_addr_d  = rb_d;
                rf_we_d    = 1'b1;
                rf_wdata_d = tmp_a_d;
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                case (op_d)
                    OP_READ:  rsp_data_d = tmp_a_d;
                    OP_WRITE: rsp_data_d = imm_d;
                    OP_ADD:   rsp_data_d = sum_d;
                    OP_SWAP:  rsp_data_d = tmp_a_d;
                    default:  rsp_data_d = '0;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= IDLE;
            op_q        <= OP_READ;
            ra_q        <= '0;
            rb_q        <= '0;
            imm_q       <= '0;
            tmp_a_q     <= '0;
            tmp_b_q     <= '0;
            rf_addr_q   <= '0;
            rf_wdata_q  <= '0;
            rf_we_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            imm_q       <= imm_d;
            tmp_a_q     <= tmp_a_d;
            tmp_b_q     <= tmp_b_d;
            rf_addr_q   <= rf_addr_d;
            rf_wdata_q  <= rf_wdata_d;
            rf_we_q     <= rf_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            req_ready_q <= req_ready_d;
        end
    end

    // Ready is also gated by Reset so it reads low from the first cycle of reset.
    assign bus.Req_Ready = req_ready_q & Reset;
    assign bus.Rsp_Valid = rsp_valid_q;
    assign bus.Rsp_Data  = rsp_data_q;
    assign bus.RF_Addr   = rf_addr_q;
    assign bus.RF_Wdata  = rf_wdata_q;
    assign bus.RF_We     = rf_we_q;
    assign Dbg_State_o   = state_q;
endmodule

// File: tb/tb_reg_access_sequencer.sv
// Directed bench for reg_access_sequencer with a behavioural register file;
// expected values are hand-computed from the file contents each step creates.
module tb_reg_access_sequencer;
    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_ADD   = 2'd2;
    localparam logic [1:0] OP_SWAP  = 2'd3;

    logic       Clk;
    logic       Reset;
    logic [2:0] dbg_state;
    int         errors = 0;
    int         checks = 0;
    int         we_cnt = 0;
    logic [2:0] we_addr_last = '0;
    logic [7:0] rf [8];
    logic [7:0] exp_q [$];

    reg_access_sequencer_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    reg_access_sequencer #(.DATA_W(8), .ADDR_W(3)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .bus         (bus),
        .Dbg_State_o (dbg_state)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // register file model: combinational read, write on the rising edge
    assign bus.RF_Rdata = rf[bus.RF_Addr];
    always @(posedge Clk) begin
        if (bus.RF_We) begin
            rf[bus.RF_Addr] <= bus.RF_Wdata;
            we_cnt          <= we_cnt + 1;
            we_addr_last    <= bus.RF_Addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
        check({tag, "_rsp_valid"}, 32'(bus.Rsp_Valid), 32'd0);
        check({tag, "_rsp_data"}, 32'(bus.Rsp_Data), 32'd0);
        check({tag, "_we"}, 32'(bus.RF_We), 32'd0);
        check({tag, "_addr"}, 32'(bus.RF_Addr), 32'd0);
        check({tag, "_wdata"}, 32'(bus.RF_Wdata), 32'd0);
    endtask

    // driver: issue one request, wait for its response, check latency and write count
    task automatic do_req(input string tag, input logic [1:0] op, input logic [2:0] ra,
                          input logic [2:0] rb, input logic [7:0] imm,
                          input int exp_lat, input logic [7:0] exp_data, input int exp_we);
        int lat;
        int we_start;
        int wait_cnt;
        logic [7:0] exp_v;
        @(negedge Clk);
        bus.Req_Valid = 1'b1;
        bus.Req_Op    = op;
        bus.Req_Ra    = ra;
        bus.Req_Rb    = rb;
        bus.Req_Imm   = imm;
        exp_q.push_back(exp_data);
        wait_cnt = 0;
        while (!bus.Req_Ready && wait_cnt < 20) begin
            @(negedge Clk);
            wait_cnt++;
        end
        check({tag, "_accept_wait"}, 32'(wait_cnt < 20), 32'd1);
        we_start = we_cnt;
        @(posedge Clk);
        @(negedge Clk);
        // scramble the request lines to show the fields were latched
        bus.Req_Valid = 1'b0;
        bus.Req_Op    = 2'($urandom_range(0, 3));
        bus.Req_Ra    = 3'($urandom_range(0, 7));
        bus.Req_Rb    = 3'($urandom_range(0, 7));
        bus.Req_Imm   = 8'($urandom_range(0, 255));
        lat = 2;
        while (!bus.Rsp_Valid && lat < 20) begin
            @(negedge Clk);
            if (!bus.Rsp_Valid) lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        exp_v = exp_q.pop_front();
        check({tag, "_rsp_data"}, 32'(bus.Rsp_Data), 32'(exp_v));
        @(negedge Clk);
        check({tag, "_ready_back"}, 32'(bus.Req_Ready), 32'd1);
        check({tag, "_we_count"}, 32'(we_cnt - we_start), 32'(exp_we));
    endtask

    initial begin
        Reset         = 1'b0;
        bus.Req_Valid = 1'b0;
        bus.Req_Op    = '0;
        bus.Req_Ra    = '0;
        bus.Req_Rb    = '0;
        bus.Req_Imm   = '0;
        bus.Rsp_Ready = 1'b1;
        for (int i = 0; i < 8; i++) rf[i] = 8'(i);

        repeat (3) @(negedge Clk);
        check("reset_ready", 32'(bus.Req_Ready), 32'd0);
        check_idle_outputs("reset");
        Reset = 1'b1;
        @(negedge Clk);

        do_req("read5", OP_READ, 3'd5, 3'd0, 8'h00, 2, 8'h05, 0);

        do_req("write3", OP_WRITE, 3'd3, 3'd0, 8'hA5, 2, 8'hA5, 1);
        check("write3_addr", 32'(we_addr_last), 32'd3);
        do_req("read3", OP_READ, 3'd3, 3'd0, 8'h00, 2, 8'hA5, 0);

        do_req("add7", OP_ADD, 3'd7, 3'd0, 8'hFB, 3, 8'h02, 1);
        check("add7_rf", 32'(rf[7]), 32'h02);
        do_req("read7", OP_READ, 3'd7, 3'd0, 8'h00, 2, 8'h02, 0);

        do_req("swap16", OP_SWAP, 3'd1, 3'd6, 8'h00, 5, 8'h01, 2);
        check("swap16_rf1", 32'(rf[1]), 32'h06);
        check("swap16_rf6", 32'(rf[6]), 32'h01);
        do_req("swap44", OP_SWAP, 3'd4, 3'd4, 8'h00, 5, 8'h04, 2);
        check("swap44_rf4", 32'(rf[4]), 32'h04);

        // response back-pressure with a competing request held on the inputs
        bus.Rsp_Ready = 1'b0;
        @(negedge Clk);
        bus.Req_Valid = 1'b1;
        bus.Req_Op    = OP_READ;
        bus.Req_Ra    = 3'd2;
        @(posedge Clk);
        @(negedge Clk);
        bus.Req_Op    = OP_WRITE;
        bus.Req_Imm   = 8'hFF;
        @(negedge Clk);
        begin
            int we_start;
            we_start = we_cnt;
            for (int i = 0; i < 10; i++) begin
                check("hold_rsp_valid", 32'(bus.Rsp_Valid), 32'd1);
                check("hold_rsp_data", 32'(bus.Rsp_Data), 32'h02);
                check("hold_req_ready", 32'(bus.Req_Ready), 32'd0);
                check("hold_we", 32'(bus.RF_We), 32'd0);
                @(negedge Clk);
            end
            bus.Req_Valid = 1'b0;
            bus.Rsp_Ready = 1'b1;
            @(negedge Clk);
            check("hold_release_ready", 32'(bus.Req_Ready), 32'd1);
            check("hold_no_write", 32'(we_cnt - we_start), 32'd0);
            check("hold_rf2", 32'(rf[2]), 32'h02);
        end

        // reset during the RDB cycle of SWAP 2,5
        begin
            int we_start;
            bus.Req_Valid = 1'b1;
            bus.Req_Op    = OP_SWAP;
            bus.Req_Ra    = 3'd2;
            bus.Req_Rb    = 3'd5;
            we_start = we_cnt;
            @(posedge Clk);
            @(negedge Clk);
            bus.Req_Valid = 1'b0;
            check("abort_rda", 32'(dbg_state), 32'd1);
            @(negedge Clk);
            check("abort_rdb", 32'(dbg_state), 32'd2);
            Reset = 1'b0;
            @(negedge Clk);
            check("abort_ready", 32'(bus.Req_Ready), 32'd0);
            check_idle_outputs("abort");
            repeat (4) @(negedge Clk);
            check("abort_no_write", 32'(we_cnt - we_start), 32'd0);
            check("abort_rf2", 32'(rf[2]), 32'h02);
            check("abort_rf5", 32'(rf[5]), 32'h05);
            Reset = 1'b1;
            @(negedge Clk);
        end

        do_req("read6_after_abort", OP_READ, 3'd6, 3'd0, 8'h00, 2, 8'h01, 0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/reg_access_sequencer.md
# reg_access_sequencer

Multi-cycle initiator that drives the single-port 8-entry x 8-bit register file on behalf of the datapath and debug logic. It accepts one request at a time over a valid/ready handshake and performs READ, WRITE, ADD-immediate and SWAP. ADD and SWAP are read-modify-write operations that the single shared address port cannot complete in one cycle, so the block sequences them as several reads and writes. It sits between the control unit and the register file and owns that file's address, write-data and write-enable lines exclusively.

## Interface
- DATA_W, 8, register width; also the width of Req_Imm and Rsp_Data.
- ADDR_W, 3, register index width; the file has 2^ADDR_W entries.

- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-low.
- Req_Valid  in  1  request present.
- Req_Ready  out  1  block can accept a request; high only in IDLE.
- Req_Op  in  2  00 READ, 01 WRITE, 10 ADD, 11 SWAP.
- Req_Ra  in  ADDR_W  primary register index.
- Req_Rb  in  ADDR_W  second index; used by SWAP only.
- Req_Imm  in  DATA_W  write data for WRITE; addend for ADD.
- Rsp_Valid  out  1  response available.
- Rsp_Ready  in  1  consumer takes the response.
- Rsp_Data  out  DATA_W  result value.
- RF_Addr  out  ADDR_W  register file index; the file's read data is combinational from it.
- RF_Wdata  out  DATA_W  register file write data.
- RF_We  out  1  register file write enable; the write commits on the next rising edge.
- RF_Rdata  in  DATA_W  register file read data.

## Operation
- States: IDLE, RDA, RDB, WRA, WRB, RESP.
- Acceptance: a request is accepted on an edge where Req_Valid=1 and Req_Ready=1.
  - Op, Ra, Rb and Imm are latched on that edge.
  - Request inputs are ignored in every other state.
- Next state after acceptance:
  - READ goes to RDA.
  - ADD goes to RDA.
  - SWAP goes to RDA.
  - WRITE goes to WRA.
- RDA: RF_Addr=Ra and RF_We=0; RF_Rdata is captured into tmp_a.
  - READ and ADD go to the next state after RDA (READ to RESP, ADD to WRA); SWAP goes to RDB.
- RDB: RF_Addr=Rb and RF_We=0; RF_Rdata is captured into tmp_b; next state is WRA.
- WRA: RF_Addr=Ra and RF_We=1. RF_Wdata depends on the op:
  - WRITE: Imm.
  - ADD: (tmp_a+Imm) mod 2^DATA_W; the carry is discarded.
  - SWAP: tmp_b.
  - SWAP goes to WRB; WRITE and ADD go to RESP.
- WRB: RF_Addr=Rb, RF_We=1, RF_Wdata=tmp_a; next state is RESP.
- RESP: Rsp_Valid=1 and Rsp_Data is held stable.
  - Rsp_Data is defined per op:
    - READ: tmp_a.
    - WRITE: Imm.
    - ADD: the sum written.
    - SWAP: old RF[Ra].
  - The block returns to IDLE on the edge where Rsp_Ready=1.
- Outside WRA and WRB, RF_We=0. Outside RDA, RDB, WRA and WRB, RF_Addr=0 and RF_Wdata=0.
- SWAP with Ra==Rb runs the full sequence, leaves the file unchanged and returns old RF[Ra].

## Timing
- Reset: an edge with Reset=0 forces IDLE and clears tmp_a, tmp_b and all latched fields.
  - Req_Ready is 0 while Reset=0.
  - Rsp_Valid=0, Rsp_Data=0, RF_We=0, RF_Addr=0 and RF_Wdata=0.
- Reset mid-operation aborts immediately; no write occurs after that edge.
  - An aborted SWAP after WRA leaves RF[Ra] updated and RF[Rb] unchanged; this is accepted behaviour.
- Latency counts edges from the accept edge to the edge that sets Rsp_Valid:
  - READ: 2.
  - WRITE: 2.
  - ADD: 3.
  - SWAP: 5.
- Register file write commit edges, counted from the accept edge:
  - WRITE: edge +2.
  - ADD: edge +3.
  - SWAP: edges +4 (Ra) and +5 (Rb).
- Throughput: one request outstanding; Req_Ready returns on the edge where the response handshake completes.
  - Back-to-back minimum spacing for READ is 3 cycles when Rsp_Ready is held high.
- Rsp_Ready held low keeps RESP indefinitely with Rsp_Data unchanged and RF_We=0.
- RF_Rdata is sampled in the same cycle RF_Addr is driven; the register file has no read latency.

## Test plan
- Reset, then READ Ra=5 with the file at RF[i]=i -> Rsp_Valid 2 edges after accept, Rsp_Data=0x05, RF_We never asserted.
- WRITE Ra=3, Imm=0xA5, then READ 3 -> RF_We pulses for exactly one cycle with RF_Addr=3; both responses return 0xA5.
- ADD Ra=7, Imm=0xFB with RF[7]=0x07 -> result wraps to 0x02; Rsp_Data=0x02; a later READ 7 returns 0x02.
- SWAP Ra=1, Rb=6 -> Rsp_Data=0x01, RF[1]=0x06, RF[6]=0x01, response 5 edges after accept; SWAP Ra=Rb=4 -> file unchanged, Rsp_Data=0x04.
- Hold Rsp_Ready=0 for 10 cycles after a READ -> Rsp_Valid and Rsp_Data stable, Req_Ready=0, and a new Req_Valid is ignored until the response handshake.
- Assert Reset=0 during the RDB cycle of SWAP 2,5 -> no RF_We afterwards, RF[2] and RF[5] unchanged, state IDLE, all outputs 0.
